// File: rtl/m6809_core_stack_seq.sv
// m6809_core_stack_seq: PSHS/PULS/PSHU/PULU sequencer, one stack byte per acknowledged cycle
// Ports: clk, reset_b (async active-low); start/ir_in/postbyte/sp_in request;
//   mem_req/mem_we/mem_addr/mem_ack memory handshake; reg_sel/reg_hi/reg_we register steering;
//   busy/done status; sp_out/sp_we/use_u stack-pointer writeback.
// Define M6809_STACK_DEAD_CYCLE_EN to insert the 6809 dead cycle between start and the first transfer.
module m6809_core_stack_seq #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic [7:0]        ir_in,
  input  logic [7:0]        postbyte,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        reg_sel,
  output logic              reg_hi,
  output logic              reg_we,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_we,
  output logic              use_u
);
`ifdef M6809_STACK_DEAD_CYCLE_EN
  typedef enum logic [1:0] {IDLE, XFER, DONE, DEAD} state_t;
`else
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
`endif
  state_t            state_q, state_d;
  logic [7:0]        mask_q, mask_d;
  logic              pull_q, pull_d;
  logic              use_u_q, use_u_d;
  logic              sec_q, sec_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [2:0]        sel;
  logic              last_byte;
  logic [7:0]        mask_clr;
  // Push walks from the highest set bit down, pull from the lowest set bit up.
  always_comb begin
    sel = 3'd0;
    for (int i = 0; i < 8; i++)
      if (mask_q[pull_q ? 7 - i : i]) sel = pull_q ? 3'(7 - i) : 3'(i);
  end
  // Bits 4-7 are 16-bit registers; sec_q marks their second byte.
  assign last_byte = ~sel[2] | sec_q;
  assign mask_clr  = mask_q & ~(8'd1 << sel);
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pull_d  = pull_q;
    use_u_d = use_u_q;
    sec_d   = sec_q;
    sp_d    = sp_q;
    case (state_q)
      IDLE: if (start && ir_in[7:2] == 6'b001101) begin
        mask_d  = postbyte;
        pull_d  = ir_in[0];
        use_u_d = ir_in[1];
        sec_d   = 1'b0;
        sp_d    = sp_in;
`ifdef M6809_STACK_DEAD_CYCLE_EN
        state_d = DEAD;
`else
        state_d = postbyte != 8'd0 ? XFER : DONE;
`endif
      end
`ifdef M6809_STACK_DEAD_CYCLE_EN
      DEAD: state_d = mask_q != 8'd0 ? XFER : DONE;
`endif
      XFER: if (mem_ack) begin
        sp_d  = pull_q ? sp_q + ADDR_W'(1) : sp_q - ADDR_W'(1);
        sec_d = ~last_byte;
        if (last_byte) begin
          mask_d = mask_clr;
          if (mask_clr == 8'd0) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      mask_q  <= 8'd0;
      pull_q  <= 1'b0;
      use_u_q <= 1'b0;
      sec_q   <= 1'b0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pull_q  <= pull_d;
      use_u_q <= use_u_d;
      sec_q   <= sec_d;
      sp_q    <= sp_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign mem_req  = state_q == XFER;
  assign mem_we   = mem_req & ~pull_q;
  assign mem_addr = mem_req ? (pull_q ? sp_q : sp_q - ADDR_W'(1)) : '0;
  assign reg_sel  = mem_req ? sel : 3'd0;
  // Push moves lo then hi, pull moves hi then lo.
  assign reg_hi   = mem_req & sel[2] & (sec_q ^ pull_q);
  assign reg_we   = mem_req & pull_q & mem_ack;
  assign sp_out   = done ? sp_q : '0;
  assign sp_we    = done;
  assign use_u    = use_u_q;
endmodule
